dco_tune_ctrl: RTL and testbench

Converts the ADPLL loop filter's digital frequency control outputs into DCO capacitor-bank codes. It sits between the loop filter and the DCO:
- integral word: `INT_OUT`
- fractional word: `Fractional_Frequency`
- flags: `overflow`, `underflow`, `OverflowP`, `UnderflowP`

It produces a registered coarse-bank binary code, a registered fine-bank thermometer code and a dither bit. Dithering uses a first-order sigma-delta modulator. Coarse retuning is driven by integral-path overflow/underflow, with a settling lockout after each step.

---
 rtl/dco_tune_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dco_tune_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl
// Converts the ADPLL loop filter's frequency control words into DCO capacitor-bank codes.
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 synchronous, active-high reset (priority over everything)
//   en                    update enable; when low, all state holds
//   INT_OUT               unsigned integral word from the loop filter (FINE_W bits)
//   Fractional_Frequency  unsigned fractional word feeding the sigma-delta modulator
//   overflow / underflow  integral path wrapped high / low (one-cycle pulses)
//   OverflowP/UnderflowP  proportional path saturated high / low
//   coarse_code           registered coarse bank binary code
//   fine_therm            registered fine bank thermometer code, bit i = (fine_code > i)
//   fine_code             registered binary fine code
//   sdm_bit               registered dither carry
//   coarse_sat            coarse_code sits at 0 or at its maximum
//   lock_busy             settling lockout after a coarse step is active
module dco_tune_ctrl #(
   parameter int unsigned COARSE_W = 4,
   parameter int unsigned FINE_W   = 5,
   parameter int unsigned FRAC_W   = 5,
   parameter int unsigned SETTLE   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [FINE_W-1:0]          INT_OUT,
   input  logic [FRAC_W-1:0]          Fractional_Frequency,
   input  logic                       overflow,
   input  logic                       underflow,
   input  logic                       OverflowP,
   input  logic                       UnderflowP,
   output logic [COARSE_W-1:0]        coarse_code,
   output logic [(2**FINE_W)-2:0]     fine_therm,
   output logic [FINE_W-1:0]          fine_code,
   output logic                       sdm_bit,
   output logic                       coarse_sat,
   output logic                       lock_busy
);

   localparam int unsigned CntW   = $clog2(SETTLE + 1);
   localparam int unsigned SumW   = FINE_W + 2;
   localparam int unsigned ThermW = (2 ** FINE_W) - 1;

   localparam logic [COARSE_W-1:0] CoarseMax   = {COARSE_W{1'b1}};
   localparam logic [COARSE_W-1:0] CoarseMaxM1 = CoarseMax - 1'b1;
   localparam logic [COARSE_W-1:0] CoarseOne   = {{(COARSE_W-1){1'b0}}, 1'b1};
   localparam logic [COARSE_W-1:0] CoarseRst   = {1'b1, {(COARSE_W-1){1'b0}}};
   localparam logic [CntW-1:0]     SettleLoad  = CntW'(SETTLE);
   localparam logic [CntW-1:0]     CntOne      = {{(CntW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {StIdle, StSettle} state_e;

   // ---------------------------------------------------------------------------------------
   // Coarse controller
   // ---------------------------------------------------------------------------------------
   state_e              state_q;
   logic [COARSE_W-1:0] coarse_q;
   logic [CntW-1:0]     cnt_q;
   logic                sat_q;
   logic                lock_q;

   logic step_up, step_dn;
   // Simultaneous flags cancel each other out.
   assign step_up = overflow & ~underflow;
   assign step_dn = underflow & ~overflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         coarse_q <= CoarseRst;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         lock_q   <= 1'b0;
      end else if (en) begin
         unique case (state_q)
            StIdle: begin
               // A step requested at a rail is dropped without entering the lockout.
               if (step_up && (coarse_q != CoarseMax)) begin
                  coarse_q <= coarse_q + 1'b1;
                  sat_q    <= (coarse_q == CoarseMaxM1);
                  cnt_q    <= SettleLoad;
                  state_q  <= StSettle;
                  lock_q   <= 1'b1;
               end else if (step_dn && (coarse_q != '0)) begin
                  coarse_q <= coarse_q - 1'b1;
                  sat_q    <= (coarse_q == CoarseOne);
                  cnt_q    <= SettleLoad;
                  state_q  <= StSettle;
                  lock_q   <= 1'b1;
               end
            end
            StSettle: begin
               // Leave on the edge where the counter reaches zero.
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q <= CntOne) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  lock_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               lock_q  <= 1'b0;
            end
         endcase
      end
   end

   assign coarse_code = coarse_q;
   assign coarse_sat  = sat_q;
   assign lock_busy   = lock_q;

   // ---------------------------------------------------------------------------------------
   // First-order sigma-delta modulator
   // ---------------------------------------------------------------------------------------
   // The accumulator's carry bit is held in sdm_q, so only the low FRAC_W bits are stored.
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              sdm_q, sdm_d;
   logic [FRAC_W:0]   sdm_sum;

   always_comb begin
      sdm_sum = {1'b0, acc_q} + {1'b0, Fractional_Frequency};
      acc_d   = sdm_sum[FRAC_W-1:0];
      sdm_d   = sdm_sum[FRAC_W];
   end

   // ---------------------------------------------------------------------------------------
   // Fine code: integral word plus previous dither carry plus proportional kick, clamped
   // ---------------------------------------------------------------------------------------
   logic signed [SumW-1:0] fine_sum;
   logic [FINE_W-1:0]      fine_q, fine_d;
   logic [ThermW-1:0]      therm_q, therm_d;

   always_comb begin
      fine_sum = $signed({2'b00, INT_OUT})
               + $signed({{(SumW-1){1'b0}}, sdm_q})
               + $signed({{(SumW-1){1'b0}}, OverflowP})
               - $signed({{(SumW-1){1'b0}}, UnderflowP});
      if (fine_sum[SumW-1]) begin
         fine_d = '0;
      end else if (fine_sum[SumW-2:FINE_W] != '0) begin
         fine_d = '1;
      end else begin
         fine_d = fine_sum[FINE_W-1:0];
      end
   end

   // Thermometer is decoded from the next fine code so both registers agree every cycle.
   always_comb begin
      therm_d = '0;
      for (int i = 0; i < ThermW; i++) begin
         therm_d[i] = (fine_d > FINE_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         sdm_q   <= 1'b0;
         fine_q  <= '0;
         therm_q <= '0;
      end else if (en) begin
         acc_q   <= acc_d;
         sdm_q   <= sdm_d;
         fine_q  <= fine_d;
         therm_q <= therm_d;
      end
   end

   assign sdm_bit    = sdm_q;
   assign fine_code  = fine_q;
   assign fine_therm = therm_q;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
module tb_dco_tune_ctrl;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [4:0]  INT_OUT, Fractional_Frequency;
   logic        overflow, underflow, OverflowP, UnderflowP;
   logic [3:0]  coarse_code;
   logic [30:0] fine_therm;
   logic [4:0]  fine_code;
   logic        sdm_bit, coarse_sat, lock_busy;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [4:0] fine;
      logic       sdm;
   } exp_t;
   exp_t sb_q[$];

   dco_tune_ctrl #(
      .COARSE_W(4),
      .FINE_W  (5),
      .FRAC_W  (5),
      .SETTLE  (4)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .en                  (en),
      .INT_OUT             (INT_OUT),
      .Fractional_Frequency(Fractional_Frequency),
      .overflow            (overflow),
      .underflow           (underflow),
      .OverflowP           (OverflowP),
      .UnderflowP          (UnderflowP),
      .coarse_code         (coarse_code),
      .fine_therm          (fine_therm),
      .fine_code           (fine_code),
      .sdm_bit             (sdm_bit),
      .coarse_sat          (coarse_sat),
      .lock_busy           (lock_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en = 1'b1;
      overflow = 1'b0; underflow = 1'b0; OverflowP = 1'b0; UnderflowP = 1'b0;
      INT_OUT = '0; Fractional_Frequency = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (coarse_code !== 4'd8) $display("FAIL reset_coarse: got %0d want 8", coarse_code);
      else n_pass++;
      n_checks++;
      if (fine_code !== 5'd0 || fine_therm !== 31'd0)
         $display("FAIL reset_fine: got %0d/%h want 0/0", fine_code, fine_therm);
      else n_pass++;
      n_checks++;
      if ({sdm_bit, coarse_sat, lock_busy} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000", {sdm_bit, coarse_sat, lock_busy});
      else n_pass++;
   endtask

   task automatic test_step_up();
      int busy;
      overflow = 1'b1; tick(); overflow = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd9 || lock_busy !== 1'b1)
         $display("FAIL step_up: got code %0d busy %b want 9 1", coarse_code, lock_busy);
      else n_pass++;
      busy = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (lock_busy === 1'b1) busy++;
      end
      n_checks++;
      if (busy != 4) $display("FAIL lock_len: got %0d cycles want 4", busy);
      else n_pass++;
   endtask

   task automatic test_lockout();
      do_reset();
      overflow = 1'b1; tick(); overflow = 1'b0;       // step at edge n
      tick();                                          // n+1
      underflow = 1'b1; tick(); underflow = 1'b0;     // n+2 masked
      tick();                                          // n+3
      underflow = 1'b1; tick(); underflow = 1'b0;     // n+4 masked
      n_checks++;
      if (coarse_code !== 4'd9 || lock_busy !== 1'b0)
         $display("FAIL lockout_mask: got code %0d busy %b want 9 0", coarse_code, lock_busy);
      else n_pass++;
      underflow = 1'b1; tick(); underflow = 1'b0;     // n+5 accepted
      n_checks++;
      if (coarse_code !== 4'd8 || lock_busy !== 1'b1)
         $display("FAIL lockout_release: got code %0d busy %b want 8 1", coarse_code, lock_busy);
      else n_pass++;
      for (int i = 0; i < 5; i++) tick();
   endtask

   task automatic test_reset_mid_settle();
      do_reset();
      overflow = 1'b1; tick(); overflow = 1'b0;
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd8 || lock_busy !== 1'b0)
         $display("FAIL mid_reset: got code %0d busy %b want 8 0", coarse_code, lock_busy);
      else n_pass++;
      underflow = 1'b1; tick(); underflow = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd7 || lock_busy !== 1'b1)
         $display("FAIL after_mid_reset: got code %0d busy %b want 7 1", coarse_code, lock_busy);
      else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         overflow = 1'b1; tick(); overflow = 1'b0;
         n_checks++;
         if (coarse_code !== 4'(8 + k) || coarse_sat !== (k == 7))
            $display("FAIL sat_up_%0d: got code %0d sat %b want %0d %b",
                     k, coarse_code, coarse_sat, 8 + k, (k == 7));
         else n_pass++;
         for (int i = 0; i < 5; i++) tick();
      end
      overflow = 1'b1; tick(); overflow = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd15 || lock_busy !== 1'b0 || coarse_sat !== 1'b1)
         $display("FAIL sat_top_hold: got code %0d busy %b sat %b want 15 0 1",
                  coarse_code, lock_busy, coarse_sat);
      else n_pass++;
      for (int k = 1; k <= 15; k++) begin
         underflow = 1'b1; tick(); underflow = 1'b0;
         n_checks++;
         if (coarse_code !== 4'(15 - k) || coarse_sat !== (k == 15))
            $display("FAIL sat_dn_%0d: got code %0d sat %b want %0d %b",
                     k, coarse_code, coarse_sat, 15 - k, (k == 15));
         else n_pass++;
         for (int i = 0; i < 5; i++) tick();
      end
      underflow = 1'b1; tick(); underflow = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd0 || lock_busy !== 1'b0 || coarse_sat !== 1'b1)
         $display("FAIL sat_bot_hold: got code %0d busy %b sat %b want 0 0 1",
                  coarse_code, lock_busy, coarse_sat);
      else n_pass++;
   endtask

   task automatic test_dither();
      int   acc_m, sdm_m, ones, elevens;
      exp_t e, got;
      do_reset();
      INT_OUT = 5'd10; Fractional_Frequency = 5'd8;
      acc_m = 0; sdm_m = 0; ones = 0; elevens = 0;
      // One extra cycle so the last carry's effect on fine_code is observed.
      for (int i = 0; i < 33; i++) begin
         e.fine = 5'(10 + sdm_m);
         acc_m  = acc_m + 8;
         sdm_m  = (acc_m >= 32) ? 1 : 0;
         acc_m  = acc_m % 32;
         e.sdm  = sdm_m[0];
         sb_q.push_back(e);
         tick();
         got = sb_q.pop_front();
         if (sdm_bit === 1'b1) ones++;
         if (fine_code === 5'd11) elevens++;
         n_checks++;
         if (fine_code !== got.fine || sdm_bit !== got.sdm)
            $display("FAIL dither_%0d: got fine %0d sdm %b want %0d %b",
                     i, fine_code, sdm_bit, got.fine, got.sdm);
         else n_pass++;
      end
      n_checks++;
      if (ones != 8 || elevens != 8)
         $display("FAIL dither_density: got ones %0d elevens %0d want 8 8", ones, elevens);
      else n_pass++;
   endtask

   task automatic test_clamp_kick();
      do_reset();
      INT_OUT = 5'd31; Fractional_Frequency = 5'd16; OverflowP = 1'b1;
      tick();                                   // acc 16, no carry
      tick();                                   // carry out
      n_checks++;
      if (sdm_bit !== 1'b1) $display("FAIL clamp_sdm: got %b want 1", sdm_bit);
      else n_pass++;
      tick();                                   // 31 + 1 + 1 clamps
      n_checks++;
      if (fine_code !== 5'd31 || fine_therm !== 31'h7FFF_FFFF)
         $display("FAIL clamp_high: got %0d/%h want 31/7fffffff", fine_code, fine_therm);
      else n_pass++;
      INT_OUT = 5'd20; Fractional_Frequency = 5'd0;
      tick();
      n_checks++;
      if (fine_code !== 5'd21 || fine_therm !== ((31'd1 << 21) - 31'd1))
         $display("FAIL kick_up: got %0d/%h want 21", fine_code, fine_therm);
      else n_pass++;
      INT_OUT = 5'd5; OverflowP = 1'b0; UnderflowP = 1'b1;
      tick();
      n_checks++;
      if (fine_code !== 5'd4 || fine_therm !== 31'h0000_000F)
         $display("FAIL kick_dn: got %0d/%h want 4/f", fine_code, fine_therm);
      else n_pass++;
      INT_OUT = 5'd0;
      tick();
      n_checks++;
      if (fine_code !== 5'd0 || fine_therm !== 31'd0)
         $display("FAIL clamp_low: got %0d/%h want 0/0", fine_code, fine_therm);
      else n_pass++;
      UnderflowP = 1'b0;
   endtask

   task automatic test_freeze();
      do_reset();
      INT_OUT = 5'd7; Fractional_Frequency = 5'd31;
      tick();                                   // acc 31, no carry
      tick();                                   // acc 30, carry
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         overflow = ~overflow;
         tick();
         n_checks++;
         if (coarse_code !== 4'd8 || fine_code !== 5'd7 || sdm_bit !== 1'b1 ||
             lock_busy !== 1'b0 || fine_therm !== 31'h0000_007F)
            $display("FAIL freeze_%0d: got code %0d fine %0d sdm %b busy %b want 8 7 1 0",
                     i, coarse_code, fine_code, sdm_bit, lock_busy);
         else n_pass++;
      end
      overflow = 1'b0; en = 1'b1; Fractional_Frequency = 5'd1;
      tick();                                   // held acc 30 + 1 = 31, no carry
      n_checks++;
      if (fine_code !== 5'd8 || sdm_bit !== 1'b0)
         $display("FAIL freeze_acc_a: got fine %0d sdm %b want 8 0", fine_code, sdm_bit);
      else n_pass++;
      tick();                                   // 31 + 1 carries
      n_checks++;
      if (sdm_bit !== 1'b1) $display("FAIL freeze_acc_b: got sdm %b want 1", sdm_bit);
      else n_pass++;
   endtask

   task automatic test_both_flags();
      do_reset();
      overflow = 1'b1; underflow = 1'b1;
      tick(); tick();
      overflow = 1'b0; underflow = 1'b0;
      n_checks++;
      if (coarse_code !== 4'd8 || lock_busy !== 1'b0)
         $display("FAIL both_flags: got code %0d busy %b want 8 0", coarse_code, lock_busy);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0;
      INT_OUT = '0; Fractional_Frequency = '0;
      overflow = 1'b0; underflow = 1'b0; OverflowP = 1'b0; UnderflowP = 1'b0;
      test_reset();
      test_step_up();
      test_lockout();
      test_reset_mid_settle();
      test_saturation();
      test_dither();
      test_clamp_kick();
      test_freeze();
      test_both_flags();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
